// File: rtl/booth_multiplier_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM encodings,
// supported operand widths and the iteration-counter sizing helper.
package booth_multiplier_pkg;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC  = 3'd2,
        DONE  = 3'd3,
        REARM = 3'd4
    } state_t;

    // Counter must hold the terminal value WIDTH; sized with one spare code.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add of a/s into the upper
// WIDTH+1 bits of the partial product, then an arithmetic shift right.
module booth_step
    import booth_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH+2:0] p_i,
    input  logic [WIDTH:0]     a_i,
    input  logic [WIDTH:0]     s_i,
    output logic [2*WIDTH+2:0] p_o
);

    logic [WIDTH:0] hi_sum;

    always_comb begin
        hi_sum = p_i[2*WIDTH+2:WIDTH+2];
        case (p_i[1:0])
            2'b01:   hi_sum = hi_sum + a_i;
            2'b10:   hi_sum = hi_sum + s_i;
            default: hi_sum = p_i[2*WIDTH+2:WIDTH+2];
        endcase
        p_o = {hi_sum[WIDTH], hi_sum, p_i[WIDTH+1:1]};
    end

endmodule

// File: rtl/booth_multiplier_param.sv
// Sequential signed/unsigned Booth multiplier with start/done handshake.
// done_sig pulses WIDTH+3 edges after the capturing start sample.
module booth_multiplier_param
    import booth_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_sig,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               done_sig,
    output logic               busy,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH:0]     SQ_a,
    output logic [WIDTH:0]     SQ_s,
    output logic [2*WIDTH+2:0] SQ_p
);

    localparam int CW = cnt_width(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("booth_multiplier_param: WIDTH out of supported range");
    end

    state_t             state_q;
    logic [WIDTH-1:0]   a_in_q;
    logic [WIDTH-1:0]   b_in_q;
    logic               mode_q;
    logic [WIDTH:0]     a_q;
    logic [WIDTH:0]     s_q;
    logic [2*WIDTH+2:0] p_q;
    logic [2*WIDTH+2:0] p_d;
    logic [CW-1:0]      cnt_q;
    logic               done_q;
    logic               busy_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;

    // The extra top bit keeps -2^(WIDTH-1) and full-range unsigned exact.
    assign a_ext = {mode_q & a_in_q[WIDTH-1], a_in_q};
    assign b_ext = {mode_q & b_in_q[WIDTH-1], b_in_q};

    booth_step #(.WIDTH(WIDTH)) u_step (
        .p_i (p_q),
        .a_i (a_q),
        .s_i (s_q),
        .p_o (p_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_in_q    <= '0;
            b_in_q    <= '0;
            mode_q    <= 1'b0;
            a_q       <= '0;
            s_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_sig) begin
                        a_in_q  <= A;
                        b_in_q  <= B;
                        mode_q  <= signed_mode;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    a_q     <= a_ext;
                    s_q     <= -a_ext;
                    p_q     <= {{(WIDTH+1){1'b0}}, b_ext, 1'b0};
                    cnt_q   <= '0;
                    state_q <= CALC;
                end
                CALC: begin
                    p_q <= p_d;
                    if (cnt_q == CW'(WIDTH)) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q    <= 1'b1;
                    product_q <= p_q[2*WIDTH:1];
                    state_q   <= REARM;
                end
                REARM: begin
                    // A start held high past done must not retrigger.
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (!start_sig) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_sig = done_q;
    assign busy     = busy_q;
    assign product  = product_q;
    assign SQ_a     = a_q;
    assign SQ_s     = s_q;
    assign SQ_p     = p_q;

endmodule

// File: doc/booth_multiplier_param.md
BOOTH_MULTIPLIER_PARAM -- requirements
Module: booth_multiplier_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start_sig  input  1  operation request, held high by the master until done_sig.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port A  input  WIDTH  multiplicand.
REQ-007 SHALL have port B  input  WIDTH  multiplier.
REQ-008 SHALL have port done_sig  output  1  one-cycle completion pulse.
REQ-009 SHALL have port busy  output  1  high from operand capture until done_sig falls.
REQ-010 SHALL have port product  output  2*WIDTH  result, signed or unsigned per captured mode.
REQ-011 SHALL have port SQ_a  output  WIDTH+1  debug: extended multiplicand register.
REQ-012 SHALL have port SQ_s  output  WIDTH+1  debug: negated extended multiplicand register.
REQ-013 SHALL have port SQ_p  output  2*WIDTH+3  debug: Booth partial-product register.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, CALC, DONE, REARM.
REQ-015 IDLE: when start_sig is sampled high, SHALL capture A, B and signed_mode on that edge (edge k) and go to LOAD; later input changes are ignored until the next IDLE.
REQ-016 LOAD: SHALL set a = extend(A), s = -extend(A), p = {0 (WIDTH+1 bits), extend(B), 1'b0}, iteration counter = 0; go to CALC. extend = sign-extend when signed_mode is set, else zero-extend, to WIDTH+1 bits.
REQ-017 CALC: each cycle SHALL add a (p[1:0]=01) or s (10) or nothing (00/11) to the upper WIDTH+1 bits of p, then arithmetically shift p right by one; run exactly WIDTH+1 iterations, then go to DONE.
REQ-018 The WIDTH+1 internal width SHALL make -2^(WIDTH-1) signed operands and full-range unsigned operands exact, with no overflow.
REQ-019 DONE: SHALL assert done_sig for exactly one cycle, with product = p[2*WIDTH:1] valid in the same cycle; go to REARM.
REQ-020 Latency: done_sig SHALL rise at edge k+WIDTH+3 and fall at edge k+WIDTH+4, independent of operand values.
REQ-021 REARM: SHALL stay until start_sig is sampled low, then go to IDLE; a start_sig held high after done_sig SHALL NOT start a second operation.
REQ-022 start_sig falling during LOAD or CALC SHALL be ignored; the operation completes normally.
REQ-023 product SHALL hold its last value from DONE until the next LOAD; debug outputs track their registers continuously.
REQ-024 busy SHALL be low in IDLE and REARM, and high in LOAD, CALC and DONE.

Reset
REQ-025 rst high SHALL immediately force IDLE; done_sig, busy, product, SQ_a, SQ_s, SQ_p and the counter go to 0.
REQ-026 rst asserted mid-operation SHALL abort without any done_sig pulse; the first operation after release requires a fresh start_sig sample in IDLE.

Structure
REQ-027 The shared package booth_multiplier_pkg SHALL hold the state encodings, the WIDTH limits, and the counter-width function (clog2(WIDTH+2)).
REQ-028 The add/subtract-and-shift datapath SHALL be one combinational sub-module, booth_step, parametrised by WIDTH and instantiated once.

Verification (WIDTH=8)
REQ-029 Signed: 2*4 -> 16'h0008; -4*5 -> 16'hFFEC; 36*-8 -> 16'hFEE0; -127*-127 -> 16'h3F01; each done_sig exactly 11 edges after the start sample.
REQ-030 Boundary signed: A=B=8'h80 -> 16'h4000; A=8'h80, B=8'h7F -> 16'hC080.
REQ-031 Unsigned: A=B=8'hFF -> 16'hFE01; A=8'h80, B=8'h02 -> 16'h0100; then the same 8'hFF*8'hFF pair with signed_mode=1 -> 16'h0001.
REQ-032 Handshake: start_sig held high 20 cycles past done_sig -> exactly one done_sig pulse; drop start_sig for 1 cycle then raise it -> second operation runs.
REQ-033 Reset mid-CALC (edge k+5) -> all outputs 0 immediately, no done_sig; next request 3*3 -> 16'h0009.
REQ-034 Operand change: A/B/signed_mode toggled every cycle after capture -> result equals the captured-operand product.
